// File: rtl/glb_stream_pkg.sv
// Shared definitions for the GLB token stream arbiter: token width, the
// end-of-stream marker, the FSM state type and small helper functions.
package glb_stream_pkg;

   localparam int GLB_DATA_W = 17;

   // Token that closes a stream; only an exact 17-bit match counts.
   localparam logic [GLB_DATA_W-1:0] DONE_TOKEN = 17'h10100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      PASS = 2'd2,
      FIN  = 2'd3
   } arb_state_e;

   // Full-width equality; tokens that share only some bits with DONE pass through.
   function automatic logic is_done_token(input logic [GLB_DATA_W-1:0] tok);
      return tok == DONE_TOKEN;
   endfunction

   // Index width for a requester count, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/glb_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after the pointer, wrapping around the requester count.
module glb_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             any_o
);

   // rot_idx[k] is the requester examined at priority position k.
   logic [IDX_W-1:0] rot_idx [N];

   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot_idx[gi] = (int'(rr_ptr_i) + gi >= N) ? IDX_W'(int'(rr_ptr_i) + gi - N)
                                                       : IDX_W'(int'(rr_ptr_i) + gi);
   end

   // Scan from lowest priority to highest so the last hit (closest to the pointer) wins.
   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[rot_idx[k]]) begin
            winner_o = rot_idx[k];
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/glb_stream_arbiter.sv
// Shares one GLB token output among NUM_REQ stream sources. A source owns the
// output from its first token through its DONE token; ownership rotates
// round-robin. Each source retires after STREAMS_PER_REQ DONE tokens and the
// block raises a sticky done once all have retired and the output has drained.
module glb_stream_arbiter
   import glb_stream_pkg::*;
#(
   parameter int  NUM_REQ         = 4,
   parameter int  DATA_W          = GLB_DATA_W,
   parameter int  STREAMS_PER_REQ = 1,
   localparam int IDX_W           = idx_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [NUM_REQ*DATA_W-1:0] in_data,
   input  logic [NUM_REQ-1:0]        in_valid,
   output logic [NUM_REQ-1:0]        in_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy,
   output logic                      done
);

   localparam logic [7:0] SPR = 8'(STREAMS_PER_REQ);

   arb_state_e        state_q;
   logic              flush_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [IDX_W-1:0]  grant_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic              busy_q;
   logic              done_q;
   logic [7:0]        cnt_q [NUM_REQ];
   logic [7:0]        cnt_d [NUM_REQ];
   logic [NUM_REQ-1:0] retired_q;
   logic [NUM_REQ-1:0] retired_d;

   logic [DATA_W-1:0] tok_arr [NUM_REQ];
   logic [DATA_W-1:0] sel_tok;
   logic [NUM_REQ-1:0] cand;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic              all_retired;
   logic              out_free;
   logic              pass_ready;
   logic              accept;
   logic              acc_done;
   logic [IDX_W-1:0]  next_ptr;

   genvar gi;

   // Unpack the per-requester token lanes.
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign tok_arr[gi] = in_data[gi*DATA_W +: DATA_W];
   end

   assign sel_tok     = tok_arr[grant_q];
   assign cand        = in_valid & ~retired_q;
   assign all_retired = &retired_q;

   glb_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i    (cand),
      .rr_ptr_i (rr_ptr_q),
      .winner_o (pick_idx),
      .any_o    (pick_any)
   );

   // The output register can take a token when empty or draining this cycle.
   assign out_free   = !out_valid_q || out_ready;
   assign pass_ready = (state_q == PASS) && !flush && out_free;
   assign accept     = pass_ready && in_valid[grant_q];
   assign acc_done   = accept && is_done_token(sel_tok);
   assign next_ptr   = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + IDX_W'(1);

   // Only the granted lane sees ready; flush masks it combinationally.
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign in_ready[gi] = pass_ready && (grant_q == IDX_W'(gi));
   end

   // Per-requester stream counters (saturating) and retirement flags.
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic hit;
      assign hit = acc_done && (grant_q == IDX_W'(gi));
      assign cnt_d[gi]     = flush ? 8'd0 :
                             (hit && cnt_q[gi] < SPR) ? cnt_q[gi] + 8'd1 : cnt_q[gi];
      assign retired_d[gi] = flush ? 1'b0 :
                             (retired_q[gi] | (hit && cnt_q[gi] >= SPR - 8'd1));
   end

   // Register stream counters and the retired mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= 8'd0;
         end
         retired_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         retired_q <= retired_d;
      end
   end

   // Control FSM plus the output token register and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         flush_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         flush_q <= flush;
         if (flush) begin
            // A held token is dropped; grant_id keeps its last value.
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
         end else begin
            if (accept) begin
               out_data_q  <= sel_tok;
               out_valid_q <= 1'b1;
            end else if (out_ready) begin
               out_valid_q <= 1'b0;
            end

            case (state_q)
               IDLE: begin
                  // Arm on the falling edge of flush.
                  if (flush_q) begin
                     state_q <= ARB;
                  end
               end
               ARB: begin
                  if (all_retired) begin
                     state_q <= FIN;
                  end else if (pick_any) begin
                     grant_q <= pick_idx;
                     busy_q  <= 1'b1;
                     state_q <= PASS;
                  end
               end
               PASS: begin
                  if (acc_done) begin
                     rr_ptr_q <= next_ptr;
                     busy_q   <= 1'b0;
                     state_q  <= ARB;
                  end
               end
               FIN: begin
                  if (!out_valid_q) begin
                     done_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign grant_id  = grant_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_glb_stream_arbiter.sv
// Bench for glb_stream_arbiter (4 requesters, 2 streams each): directed
// scenarios with literal expectations, then randomized epochs, all compared
// every cycle against a transaction-level model of the arbitration rules.
module tb_glb_stream_arbiter;

   localparam int N = 4;
   localparam int W = 17;
   localparam int S = 2;
   localparam logic [W-1:0] DONE = 17'h10100;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flush;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [1:0]     grant_id;
   logic           busy;
   logic           done;

   always #5 clk = ~clk;

   glb_stream_arbiter #(
      .NUM_REQ         (N),
      .DATA_W          (W),
      .STREAMS_PER_REQ (S)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_id  (grant_id),
      .busy      (busy),
      .done      (done)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Source side: a queue of pending tokens per requester.
   logic [W-1:0] src_q [N][$];
   int           valid_pct = 100;
   bit           junk_en   = 1'b0;
   bit [N-1:0]   hs_seen;

   // Model: armed/finished flags, current owner (-1 while choosing), pointer,
   // per-requester completed-stream counts and the output slot.
   bit           m_armed, m_fin, m_flush_q, m_ovalid, m_done;
   int           m_owner, m_ptr, m_gid;
   int           m_cnt [N];
   logic [W-1:0] m_odata;

   // Observations for the literal checks.
   logic [W-1:0] obs_data[$];
   int           obs_cyc[$];
   int           gnt_log[$];
   int           done_cyc = -1;
   bit           busy_prev = 1'b0, done_prev = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void model_reset();
      m_armed = 0; m_fin = 0; m_flush_q = 0; m_ovalid = 0; m_done = 0;
      m_owner = -1; m_ptr = 0; m_gid = 0; m_odata = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endfunction

   // One clock edge of the arbitration rules, from the current bench inputs.
   function automatic void model_edge();
      bit ov_old, all_ret, found;
      int j;
      logic [W-1:0] tok;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ov_old = m_ovalid;
      if (flush) begin
         m_armed = 0; m_fin = 0; m_owner = -1; m_ptr = 0; m_ovalid = 0; m_done = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (!m_armed) begin
         if (m_flush_q) m_armed = 1;
      end else if (m_fin) begin
         if (out_ready) m_ovalid = 0;
         if (!ov_old) m_done = 1;
      end else if (m_owner < 0) begin
         if (out_ready) m_ovalid = 0;
         all_ret = 1;
         for (int i = 0; i < N; i++) if (m_cnt[i] < S) all_ret = 0;
         if (all_ret) m_fin = 1;
         else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (!found && in_valid[j] && m_cnt[j] < S) begin
                  found = 1; m_owner = j; m_gid = j;
               end
            end
         end
      end else begin
         tok = in_data[m_owner*W +: W];
         if (in_valid[m_owner] && (!m_ovalid || out_ready)) begin
            m_odata = tok; m_ovalid = 1;
            if (tok == DONE) begin
               if (m_cnt[m_owner] < S) m_cnt[m_owner]++;
               m_ptr = (m_owner + 1) % N;
               m_owner = -1;
            end
         end else if (out_ready) begin
            m_ovalid = 0;
         end
      end
      m_flush_q = flush;
   endfunction

   function automatic void compare_outputs();
      bit exp_busy;
      logic [N-1:0] exp_rdy;
      exp_busy = m_armed && !m_fin && m_owner >= 0;
      for (int i = 0; i < N; i++)
         exp_rdy[i] = rst_n && !flush && exp_busy && m_owner == i && (!m_ovalid || out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_ovalid);
      if (m_ovalid) chk("out_data", out_data, m_odata);
      chk("grant_id", grant_id, m_gid);
      chk("busy", busy, exp_busy);
      chk("done", done, m_done);
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
   endfunction

   // Drive each requester from the head of its queue.
   function automatic void present();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            in_valid[i] = (valid_pct >= 100) || ($urandom_range(0, 99) < valid_pct);
            in_data[i*W +: W] = src_q[i][0];
         end else begin
            in_valid[i] = junk_en && ($urandom_range(0, 3) == 0);
            in_data[i*W +: W] = 17'($urandom);
         end
      end
   endfunction

   function automatic bit q_nonempty();
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1;
      return 0;
   endfunction

   function automatic void clear_srcs();
      for (int i = 0; i < N; i++) src_q[i].delete();
   endfunction

   function automatic void clear_obs();
      obs_data.delete(); obs_cyc.delete(); gnt_log.delete(); done_cyc = -1;
   endfunction

   // One cycle: compare at negedge, advance model at posedge, update sources after.
   task automatic step();
      logic [W-1:0] dummy;
      @(negedge clk);
      cyc++;
      compare_outputs();
      hs_seen = in_valid & in_ready;
      if (out_valid && out_ready) begin
         obs_data.push_back(out_data);
         obs_cyc.push_back(cyc);
      end
      if (busy && !busy_prev) gnt_log.push_back(int'(grant_id));
      if (done && !done_prev) done_cyc = cyc;
      busy_prev = busy;
      done_prev = done;
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < N; i++)
         if (hs_seen[i] && src_q[i].size() > 0) dummy = src_q[i].pop_front();
      present();
   endtask

   task automatic arm(input int len);
      flush = 1'b1;
      repeat (len) step();
      flush = 1'b0;
   endtask

   task automatic run_drain(input int budget, input string tag);
      int n = 0;
      while ((q_nonempty() || m_ovalid) && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < budget), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [W-1:0] t1_exp [4];
      logic [W-1:0] r;

      rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_data = '0;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      // Reset values.
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Basic arming: one requester, one stream at full rate.
      arm(3);
      out_ready = 1'b1;
      clear_obs();
      src_q[0].push_back(17'd5); src_q[0].push_back(17'd6);
      src_q[0].push_back(17'd7); src_q[0].push_back(DONE);
      present();
      run_drain(50, "t1");
      t1_exp[0] = 17'd5; t1_exp[1] = 17'd6; t1_exp[2] = 17'd7; t1_exp[3] = DONE;
      chk("t1_count", obs_data.size(), 4);
      for (int k = 0; k < obs_data.size() && k < 4; k++) chk("t1_data", obs_data[k], t1_exp[k]);
      for (int k = 1; k < obs_cyc.size(); k++) chk("t1_gap", obs_cyc[k] - obs_cyc[k-1], 1);
      chk("t1_grants", gnt_log.size(), 1);
      if (gnt_log.size() > 0) chk("t1_grant0", gnt_log[0], 0);

      // Round robin over two rounds; the second round retires everyone.
      arm(1);
      clear_obs();
      for (int i = 0; i < N; i++)
         for (int s = 0; s < S; s++) begin
            src_q[i].push_back(17'(i*16 + s*4 + 1));
            src_q[i].push_back(17'(i*16 + s*4 + 2));
            src_q[i].push_back(DONE);
         end
      present();
      n = 0;
      while (!m_done && n < 200) begin step(); n++; end
      step();
      chk("t2_timeout", 32'(n < 200), 1);
      chk("t2_count", obs_data.size(), 24);
      for (int k = 0; k < obs_data.size() && k < 24; k++) begin
         if (k % 3 == 2) chk("t2_data", obs_data[k], DONE);
         else chk("t2_data", obs_data[k], 17'(((k / 3) % 4) * 16 + (k / 12) * 4 + (k % 3) + 1));
         if (k > 0) chk("t2_gap", obs_cyc[k] - obs_cyc[k-1], (k % 3 == 0) ? 2 : 1);
      end
      chk("t2_grants", gnt_log.size(), 8);
      for (int k = 0; k < gnt_log.size() && k < 8; k++) chk("t2_grant_order", gnt_log[k], k % 4);
      if (obs_cyc.size() == 24) chk("t2_done_cycle", done_cyc, obs_cyc[23] + 2);

      // Flush mid-stream, then pointer restarts from 0.
      arm(1);
      clear_obs();
      src_q[1].push_back(17'h21); src_q[1].push_back(DONE);
      src_q[1].push_back(17'h31); src_q[1].push_back(17'h32);
      src_q[1].push_back(17'h33); src_q[1].push_back(17'h34); src_q[1].push_back(DONE);
      present();
      n = 0;
      while (obs_data.size() < 5 && n < 40) begin step(); n++; end
      chk("t5_reach", 32'(n < 40), 1);
      chk("t5_busy_before", busy, 1);
      flush = 1'b1;
      #1;
      chk("t5_in_ready_flush", in_ready, 0);
      clear_srcs();
      present();
      step();
      chk("t5_out_valid_after", out_valid, 0);
      flush = 1'b0;
      clear_obs();
      src_q[1].push_back(17'h41); src_q[1].push_back(DONE);
      src_q[3].push_back(17'h51); src_q[3].push_back(DONE);
      present();
      run_drain(60, "t5");
      chk("t5_grants", gnt_log.size(), 2);
      if (gnt_log.size() == 2) begin
         chk("t5_first_grant", gnt_log[0], 1);
         chk("t5_second_grant", gnt_log[1], 3);
      end

      // Near-miss token keeps the grant.
      arm(1);
      clear_obs();
      src_q[2].push_back(17'h00100); src_q[2].push_back(17'd9); src_q[2].push_back(DONE);
      present();
      run_drain(40, "t6a");
      chk("t6a_count", obs_data.size(), 3);
      if (obs_data.size() == 3) begin
         chk("t6a_near_miss", obs_data[0], 17'h00100);
         chk("t6a_data", obs_data[1], 17'd9);
         chk("t6a_done_tok", obs_data[2], DONE);
      end
      chk("t6a_grants", gnt_log.size(), 1);
      if (gnt_log.size() > 0) chk("t6a_grant", gnt_log[0], 2);

      // Asynchronous reset between edges while streaming.
      arm(1);
      for (int k = 1; k <= 6; k++) src_q[0].push_back(17'(k));
      src_q[0].push_back(DONE);
      present();
      repeat (4) step();
      chk("t6b_busy_before", busy, 1);
      chk("t6b_ready_before", in_ready, 4'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("t6b_in_ready", in_ready, 0);
      chk("t6b_out_valid", out_valid, 0);
      chk("t6b_out_data", out_data, 0);
      chk("t6b_busy", busy, 0);
      chk("t6b_grant_id", grant_id, 0);
      chk("t6b_done", done, 0);
      model_reset();
      clear_srcs();
      present();
      step();
      rst_n = 1'b1;

      // Randomized epochs: random stream lengths, valid gaps, backpressure.
      for (int ep = 0; ep < 6; ep++) begin
         valid_pct = 70;
         junk_en = 1'b1;
         clear_srcs();
         for (int i = 0; i < N; i++)
            for (int s = 0; s < S; s++) begin
               for (int k = $urandom_range(0, 4); k > 0; k--) begin
                  r = ($urandom_range(0, 7) == 0) ? 17'h00100 : 17'($urandom);
                  if (r == DONE) r = r ^ 17'd1;
                  src_q[i].push_back(r);
               end
               src_q[i].push_back(DONE);
            end
         arm($urandom_range(1, 3));
         n = 0;
         while (!m_done && n < 800) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
         end
         out_ready = 1'b1;
         step();
         chk("rand_epoch_done", done, 1);
         chk("rand_srcs_drained", 32'(q_nonempty()), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/glb_stream_arbiter.md
# glb_stream_arbiter

Shares one global-buffer (GLB) token stream port among NUM_REQ stream sources, such as GLB read/write channels, each emitting 17-bit tokens under valid/ready. A requester keeps the grant for a whole stream, from its first token through its DONE token (17'h10100). Arbitration between streams is round-robin. The block sits between the GLB-side sources and a single fabric IO tile input. It reports `done` once every requester has delivered STREAMS_PER_REQ streams.

## Interface
- NUM_REQ, default 4: number of requesters, 1..16.
- DATA_W, default 17: token width.
- STREAMS_PER_REQ, default 1: DONE tokens per requester before that requester retires, 1..255.
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear; streaming arms on its falling edge.
- in_data  input  NUM_REQ*DATA_W  requester tokens, packed; requester i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_REQ  per-requester valid.
- in_ready  output  NUM_REQ  per-requester ready.
- out_data  output  DATA_W  registered token.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- grant_id  output  $clog2(NUM_REQ) (min 1)  current or last granted requester.
- busy  output  1  high in PASS.
- done  output  1  sticky; all requesters retired and output register empty.

## Operation
- States: IDLE, ARB, PASS, FIN.
- **IDLE**
  - Entered on reset or whenever flush=1.
  - Leaves to ARB on the first cycle where flush=0 and flush_q=1. flush_q is flush registered by one cycle.
- **ARB**
  - Candidates are requesters with in_valid=1 and retired=0.
  - Pick the first candidate at or after rr_ptr, wrapping modulo NUM_REQ.
  - On a pick: grant_id ← winner; go to PASS.
  - No candidate: stay in ARB.
  - All requesters retired: go to FIN.
- **PASS**
  - in_ready[grant_id] = (!out_valid || out_ready). Every other in_ready bit is 0.
  - Accept means in_valid[g] && in_ready[g]. On accept: out_data ← token; out_valid ← 1.
  - If the accepted token == 17'h10100:
    - cnt[g]++.
    - If cnt[g] reaches STREAMS_PER_REQ, set retired[g].
    - rr_ptr ← (g+1) mod NUM_REQ.
    - Go to ARB.
- **FIN**
  - done=1 once out_valid=0.
  - Stays until flush or reset.
- Output register:
  - out_valid clears when out_ready=1 and no new accept happens.
  - While out_valid=1 && out_ready=0, out_data is held stable.
- Counters: cnt is 8 bits per requester and saturates at STREAMS_PER_REQ.
- Token contents are not inspected except for the DONE comparison. Full 17-bit equality is required; 17'h00100 is not DONE.

## Timing
- Reset values:
  - state=IDLE, flush_q=0, out_valid=0, out_data=0.
  - in_ready=0, grant_id=0, busy=0, done=0.
  - rr_ptr=0, all cnt=0, all retired=0.
- Handover cost:
  - Requester valid in ARB at cycle t → grant registered at t+1 → first accept possible at t+1.
  - Each stream handover therefore costs exactly one bubble cycle (the ARB cycle).
- Latency: accept at edge t → out_valid=1 and out_data visible after edge t.
- Throughput in PASS: one token per cycle while out_ready=1.
- Flush and reset behaviour:
  - flush=1 in any state clears state, counters, retired, rr_ptr and out_valid on the next edge, and forces in_ready=0 combinationally.
  - A token held in the output register during flush is dropped.
  - Flush wins over a simultaneous DONE accept.
  - rst_n low mid-stream clears everything asynchronously; in_ready drops immediately.
- Requester behaviour during its grant:
  - Dropping in_valid mid-stream keeps the grant; the block waits indefinitely.
  - A requester raising in_valid after retiring is ignored.
- NUM_REQ=1: rr_ptr stays 0; each stream still passes through ARB.

## Structure
- Package glb_stream_pkg holds:
  - DONE_TOKEN = 17'h10100.
  - GLB_DATA_W = 17.
  - The state enum {IDLE, ARB, PASS, FIN}.
  - An is_done_token() function.
- Sub-module glb_rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any.
- The top-level module holds the FSM, counters, retired mask and output register.

## Test plan
1. **Basic arming:** reset, flush pulse 3 cycles; req0 sends 5,6,7,10100 with out_ready=1 → out_data sequence 5,6,7,10100 at one token per cycle; done=1 one cycle after 10100 drains (NUM_REQ=1).
2. **Round-robin order:** NUM_REQ=4, all valid from cycle 0, each sends 2 data tokens + DONE → grant order 0,1,2,3; exactly one bubble between streams; done after 12 output tokens.
3. **Backpressure:** out_ready toggles 1,0,0,1 during a stream → out_data stable while out_ready=0, no token lost or duplicated, in_ready low while out_valid && !out_ready.
4. **Multiple streams per requester:** STREAMS_PER_REQ=2, req2 only → req2 granted twice; retired[2] set after the second 10100; FIN reached only once req0/1/3 also finish.
5. **Flush mid-stream:** flush asserted after 3 tokens of req1 → in_ready all 0 the same cycle, out_valid=0 next cycle, cnt cleared; after re-arm, req1 is regranted from rr_ptr=0.
6. **Async reset and near-miss token:** rst_n pulled low between edges during PASS → all outputs at reset values before the next edge. Separately, token 17'h00100 → passes through, grant retained.
